i2c_multi_scan: RTL



---
 rtl/i2c_multi_scan.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_multi_scan.sv
// Multi-bus I2C address scanner: START, addr+W, ACK sample, STOP per address, one result strobe each.
// A probe takes 43 quarter-bit periods plus ARM/NEXT cycles; targets may stretch SCL up to STRETCH_MAX.
module i2c_multi_scan #(
  parameter int         NUM_CH        = 2,
  parameter int         I2C_PRESCALER = 250,
  parameter logic [6:0] ADDR_FIRST    = 7'h08,
  parameter logic [6:0] ADDR_LAST     = 7'h77,
  parameter int         STRETCH_MAX   = 4096,
  localparam int        CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_trg,
  input  logic [NUM_CH-1:0] i_ch_mask,
  input  logic [NUM_CH-1:0] scl_i,
  input  logic [NUM_CH-1:0] sda_i,
  output logic [NUM_CH-1:0] scl_o,
  output logic [NUM_CH-1:0] sda_o,
  output logic [NUM_CH-1:0] scl_t,
  output logic [NUM_CH-1:0] sda_t,
  output logic              o_bsy,
  output logic              o_stb,
  output logic [CW-1:0]     o_ch,
  output logic [6:0]        o_addr,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_done,
  output logic [7:0]        o_found
);
  localparam int QW = $clog2(I2C_PRESCALER);
  localparam int SW = $clog2(STRETCH_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_BIT, S_ACK, S_STOP, S_NEXT, S_DONE} state_t;

  state_t            st;
  logic [NUM_CH-1:0] mask;
  logic [CW-1:0]     ch;
  logic [6:0]        addr;
  logic [7:0]        shreg;
  logic [2:0]        bit_idx;
  logic [1:0]        q;
  logic [QW-1:0]     qcnt;
  logic [SW-1:0]     scnt;
  logic              ack_r;
  logic              err_r;
  logic [CW-1:0]     first_ch;
  logic              first_vld;
  logic [CW-1:0]     nxt_ch;
  logic              nxt_vld;
  logic              sc;
  logic              sd;
  logic              q_end;
  logic              stall;

  assign scl_o = '0;
  assign sda_o = '0;
  assign sc    = scl_i[ch];
  assign sd    = sda_i[ch];
  assign q_end = (qcnt == QW'(I2C_PRESCALER - 1));
  // Released-SCL quarters hold their counter at zero until the target lets SCL rise.
  assign stall = ((st == S_BIT) || (st == S_ACK) || (st == S_STOP)) && (q == 2'd1) &&
                 (qcnt == '0) && !sc;

  always_comb begin
    first_ch  = '0;
    first_vld = 1'b0;
    nxt_ch    = '0;
    nxt_vld   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) begin
        first_ch  = CW'(i);
        first_vld = 1'b1;
      end
      if (mask[i] && (CW'(i) > ch)) begin
        nxt_ch  = CW'(i);
        nxt_vld = 1'b1;
      end
    end
  end

  function automatic logic [NUM_CH-1:0] pin_lo(input logic [CW-1:0] c, input logic lo);
    pin_lo    = '1;
    pin_lo[c] = ~lo;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      mask    <= '0;
      ch      <= '0;
      addr    <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      q       <= '0;
      qcnt    <= '0;
      scnt    <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      scl_t   <= '1;
      sda_t   <= '1;
      o_bsy   <= 1'b0;
      o_stb   <= 1'b0;
      o_ch    <= '0;
      o_addr  <= '0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_done  <= 1'b0;
      o_found <= '0;
    end else begin
      o_stb  <= 1'b0;
      o_done <= 1'b0;
      case (st)
        S_IDLE: if (i_trg) begin
          mask    <= i_ch_mask;
          o_found <= '0;
          o_bsy   <= 1'b1;
          addr    <= ADDR_FIRST;
          ch      <= first_ch;
          st      <= first_vld ? S_ARM : S_DONE;
        end
        S_ARM: begin
          ack_r <= 1'b0;
          q     <= '0;
          qcnt  <= '0;
          scnt  <= '0;
          if (!sc || !sd) begin
            err_r <= 1'b1;
            st    <= S_NEXT;
          end else begin
            err_r <= 1'b0;
            st    <= S_START;
          end
        end
        S_START, S_BIT, S_ACK, S_STOP: begin
          if (stall) begin
            if (scnt == SW'(STRETCH_MAX)) begin
              scl_t <= '1;
              sda_t <= '1;
              ack_r <= 1'b0;
              err_r <= 1'b1;
              st    <= S_NEXT;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end else if (!q_end) begin
            qcnt <= qcnt + QW'(1);
          end else begin
            qcnt <= '0;
            scnt <= '0;
            q    <= q + 2'd1;
            case (st)
              S_START: case (q)
                2'd0: sda_t <= pin_lo(ch, 1'b1);
                2'd1: scl_t <= pin_lo(ch, 1'b1);
                default: begin
                  st      <= S_BIT;
                  q       <= 2'd0;
                  bit_idx <= 3'd7;
                  shreg   <= {addr, 1'b0};
                  sda_t   <= pin_lo(ch, ~addr[6]);
                end
              endcase
              S_BIT, S_ACK: case (q)
                2'd0: scl_t <= '1;
                2'd2: begin
                  scl_t <= pin_lo(ch, 1'b1);
                  if (st == S_ACK) ack_r <= ~sd;
                end
                2'd3: begin
                  if (st == S_ACK) begin
                    st    <= S_STOP;
                    sda_t <= pin_lo(ch, 1'b1);
                  end else if (bit_idx == 3'd0) begin
                    st    <= S_ACK;
                    sda_t <= '1;
                  end else begin
                    bit_idx <= bit_idx - 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                    sda_t   <= pin_lo(ch, ~shreg[6]);
                  end
                end
                default: ;
              endcase
              default: case (q)
                2'd0: scl_t <= '1;
                2'd1: sda_t <= '1;
                2'd3: st <= S_NEXT;
                default: ;
              endcase
            endcase
          end
        end
        S_NEXT: begin
          o_stb  <= 1'b1;
          o_ch   <= ch;
          o_addr <= addr;
          o_ack  <= ack_r;
          o_err  <= err_r;
          if (ack_r && (o_found != 8'hFF)) o_found <= o_found + 8'd1;
          // A faulted channel is abandoned rather than probed address by address.
          if (err_r || (addr == ADDR_LAST)) begin
            addr <= ADDR_FIRST;
            ch   <= nxt_ch;
            st   <= nxt_vld ? S_ARM : S_DONE;
          end else begin
            addr <= addr + 7'd1;
            st   <= S_ARM;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_bsy  <= 1'b0;
          st     <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
